// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// the CPU load/store path and an external loader/debug port.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  input  logic          ext_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  state_t state;
  state_t next_state;
  logic   owner;
  logic   last_owner;
  logic   cpu_elig;
  logic   ext_elig;
  logic   grant;
  logic   grant_owner;

  assign cpu_stall = cpu_req & ~cpu_ack;

  // Eligibility and round-robin pick; a tie goes to whoever did not own last.
  always_comb begin
    cpu_elig    = cpu_req & ~ext_lock;
    ext_elig    = ext_req;
    grant       = cpu_elig | ext_elig;
    grant_owner = OWN_CPU;
    if (cpu_elig && ext_elig) begin
      grant_owner = ~last_owner;
    end else if (ext_elig) begin
      grant_owner = OWN_EXT;
    end else begin
      grant_owner = OWN_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = grant ? ISSUE : IDLE;
      ISSUE:   next_state = CAPT;
      CAPT:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs: memory command, owner bookkeeping, read capture, acks.
  always_ff @(posedge clk) begin
    if (clrn) begin
      owner      <= OWN_CPU;
      last_owner <= OWN_EXT;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {AW{1'b0}};
      mem_wdata  <= {DW{1'b0}};
      cpu_ack    <= 1'b0;
      ext_ack    <= 1'b0;
      cpu_rdata  <= {DW{1'b0}};
      ext_rdata  <= {DW{1'b0}};
    end else begin
      cpu_ack <= 1'b0;
      ext_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner      <= grant_owner;
            last_owner <= grant_owner;
            mem_en     <= 1'b1;
            if (grant_owner == OWN_EXT) begin
              mem_we    <= ext_we;
              mem_addr  <= ext_addr;
              mem_wdata <= ext_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
        end
        CAPT: begin
          // mem_rdata answers the ISSUE cycle; stores leave rdata untouched.
          if (!mem_we) begin
            if (owner == OWN_EXT) begin
              ext_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
          end
          if (owner == OWN_EXT) begin
            ext_ack <= 1'b1;
          end else begin
            cpu_ack <= 1'b1;
          end
        end
        DONE: begin
          mem_en <= 1'b0;
        end
        default: begin
          mem_en <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of CPU stall cycles.
  always_ff @(posedge clk) begin
    if (clrn) begin
      wait_cnt <= {CW{1'b0}};
    end else if (cpu_stall && (wait_cnt != {CW{1'b1}})) begin
      wait_cnt <= wait_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

endmodule
